// File: rtl/ws_array_ctrl.sv
// Control sequencer for an N x N weight-stationary systolic array: clear, load
// weights row by row, then stream a skewed activation tile and flag valid columns.
module ws_array_ctrl #(
    parameter int N    = 4,
    parameter int MAXM = 16,
    parameter int AW   = $clog2(MAXM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [$clog2(MAXM+1)-1:0] num_vec,
    output logic                      busy,
    output logic                      done,
    output logic                      pe_rstn_pipe,
    output logic                      pe_rstn_psum,
    output logic                      w_wr_en,
    output logic [$clog2(N)-1:0]      w_row,
    output logic                      act_rd_en,
    output logic [AW-1:0]             act_rd_addr,
    output logic [N-1:0]              feed_en,
    output logic [N-1:0]              col_valid
);
    localparam int MW = $clog2(MAXM+1);
    localparam int CW = $clog2(2*N+MAXM+1);
    localparam int RW = $clog2(N);
    localparam int XW = CW + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, STREAM, DONE} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [MW-1:0]  m_reg, m_n;
    logic           ab_reg, ab_n;
    logic           rst_q;
    logic [XW-1:0]  c_x, m_x, last_c;

    // Window bounds are evaluated one bit wider so i+1+M and N+1+j+M cannot wrap.
    assign c_x    = XW'(cnt);
    assign m_x    = XW'(m_reg);
    assign last_c = XW'(2*N) + m_x - XW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            m_reg  <= '0;
            ab_reg <= 1'b0;
            rst_q  <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            m_reg  <= m_n;
            ab_reg <= ab_n;
            rst_q  <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        m_n     = m_reg;
        ab_n    = ab_reg;
        if (abort && state != IDLE) begin
            state_n = CLEAR;
            cnt_n   = '0;
            ab_n    = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_n     = (num_vec > MW'(MAXM)) ? MW'(MAXM) : num_vec;
                        state_n = CLEAR;
                        cnt_n   = '0;
                        ab_n    = 1'b0;
                    end
                end
                CLEAR: begin
                    cnt_n = '0;
                    if (ab_reg) begin
                        state_n = IDLE;
                        ab_n    = 1'b0;
                        m_n     = '0;
                    end else begin
                        state_n = LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (cnt == CW'(N-1)) begin
                        cnt_n   = '0;
                        state_n = (m_reg == '0) ? DONE : STREAM;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                STREAM: begin
                    if (c_x == last_c) begin
                        cnt_n   = '0;
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Moore decode: outputs depend only on registered state, counter and M.
    always_comb begin
        busy         = (state == CLEAR) || (state == LOAD_W) || (state == STREAM);
        done         = (state == DONE);
        pe_rstn_pipe = !(state == CLEAR) && !rst_q;
        pe_rstn_psum = !(state == CLEAR) && !rst_q;
        w_wr_en      = (state == LOAD_W);
        w_row        = (state == LOAD_W) ? RW'(cnt) : '0;
        act_rd_en    = (state == STREAM) && (c_x < m_x);
        act_rd_addr  = act_rd_en ? AW'(cnt) : '0;
        feed_en      = '0;
        col_valid    = '0;
        if (state == STREAM) begin
            for (int i = 0; i < N; i++) begin
                feed_en[i]   = (c_x >= XW'(i+1)) && (c_x < XW'(i+1) + m_x);
                col_valid[i] = (c_x >= XW'(N+1+i)) && (c_x < XW'(N+1+i) + m_x);
            end
        end
    end
endmodule

// File: tb/tb_ws_array_ctrl.sv
// Bench for ws_array_ctrl: a timeline model (cycles since start) predicts every
// output each cycle; directed tiles plus random start/abort/rst traffic.
module tb_ws_array_ctrl;
    localparam int N    = 4;
    localparam int MAXM = 16;
    localparam int AW   = $clog2(MAXM);
    localparam int NVW  = $clog2(MAXM+1);
    localparam int RW   = $clog2(N);
    localparam int MI = 0, MT = 1, MA = 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [NVW-1:0] num_vec = '0;
    logic busy, done, pe_rstn_pipe, pe_rstn_psum, w_wr_en, act_rd_en;
    logic [RW-1:0] w_row;
    logic [AW-1:0] act_rd_addr;
    logic [N-1:0] feed_en, col_valid;

    ws_array_ctrl #(.N(N), .MAXM(MAXM), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vec(num_vec),
        .busy(busy), .done(done), .pe_rstn_pipe(pe_rstn_pipe), .pe_rstn_psum(pe_rstn_psum),
        .w_wr_en(w_wr_en), .w_row(w_row), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
        .feed_en(feed_en), .col_valid(col_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mode: idle / inside a tile k cycles after its start / abort clear cycle
    typedef struct {
        int mode;
        int k;
        int m;
        bit rf;
    } mdl_t;

    typedef struct {
        logic busy, done, prp, prs, wen, ard;
        int wrow, aaddr;
        logic [N-1:0] feed, cv;
    } exp_t;

    mdl_t mdl = '{MI, 0, 0, 1'b1};
    int total = 0, bad = 0;
    bit chk_on = 0;
    int done_cnt = 0, last_done = -1, busy_cnt = 0, rd_cnt = 0, last_addr = -1;
    int feed_bits = 0, cv_bits = 0;

    function automatic int done_k(int m);
        return N + 2 + ((m > 0) ? (2*N + m) : 0);
    endfunction

    function automatic mdl_t step(mdl_t s, logic r, logic ab, logic st, int nv);
        mdl_t n = s;
        n.rf = 1'b0;
        if (r) begin
            n.mode = MI; n.k = 0; n.m = 0; n.rf = 1'b1;
        end else if (ab && s.mode != MI) begin
            n.mode = MA;
        end else if (s.mode == MA) begin
            n.mode = MI;
        end else if (s.mode == MT) begin
            n.k = s.k + 1;
            if (n.k > done_k(s.m)) n.mode = MI;
        end else if (st) begin
            n.mode = MT; n.k = 1; n.m = (nv > MAXM) ? MAXM : nv;
        end
        return n;
    endfunction

    function automatic exp_t expect_of(mdl_t s);
        exp_t e;
        int s0, len, c;
        e.busy = 0; e.done = 0; e.prp = 1; e.prs = 1; e.wen = 0; e.ard = 0;
        e.wrow = 0; e.aaddr = 0; e.feed = '0; e.cv = '0;
        s0 = N + 2;
        len = (s.m > 0) ? (2*N + s.m) : 0;
        if (s.mode == MI) begin
            if (s.rf) begin e.prp = 0; e.prs = 0; end
        end else if (s.mode == MA) begin
            e.busy = 1; e.prp = 0; e.prs = 0;
        end else if (s.k == 1) begin
            e.busy = 1; e.prp = 0; e.prs = 0;
        end else if (s.k <= N + 1) begin
            e.busy = 1; e.wen = 1; e.wrow = s.k - 2;
        end else if (s.k < s0 + len) begin
            e.busy = 1;
            c = s.k - s0;
            if (c < s.m) begin e.ard = 1; e.aaddr = c; end
            for (int i = 0; i < N; i++) begin
                e.feed[i] = (c >= i + 1) && (c < i + 1 + s.m);
                e.cv[i]   = (c >= N + 1 + i) && (c < N + 1 + i + s.m);
            end
        end else begin
            e.done = 1;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    always @(posedge clk) mdl <= step(mdl, rst, abort, start, int'(num_vec));

    always @(negedge clk) begin
        exp_t e;
        if (chk_on) begin
            e = expect_of(mdl);
            cmp("busy", busy, e.busy);
            cmp("done", done, e.done);
            cmp("pe_rstn_pipe", pe_rstn_pipe, e.prp);
            cmp("pe_rstn_psum", pe_rstn_psum, e.prs);
            cmp("w_wr_en", w_wr_en, e.wen);
            cmp("w_row", w_row, e.wrow);
            cmp("act_rd_en", act_rd_en, e.ard);
            cmp("act_rd_addr", act_rd_addr, e.aaddr);
            cmp("feed_en", feed_en, e.feed);
            cmp("col_valid", col_valid, e.cv);
            if (done === 1'b1) begin done_cnt++; last_done = cyc; end
            if (busy === 1'b1) busy_cnt++;
            if (act_rd_en === 1'b1) begin rd_cnt++; last_addr = int'(act_rd_addr); end
            feed_bits += $countones(feed_en);
            cv_bits   += $countones(col_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, d0, b0, r0, f0, c0;
        repeat (3) tick();
        chk_on = 1;
        rst = 0;
        repeat (3) tick();

        // M=3 tile
        t0 = cyc; d0 = done_cnt; b0 = busy_cnt; r0 = rd_cnt; f0 = feed_bits; c0 = cv_bits;
        start = 1; num_vec = 3; tick(); start = 0;
        repeat (25) tick();
        cmp("m3_done_cycle", last_done - t0, 17);
        cmp("m3_done_count", done_cnt - d0, 1);
        cmp("m3_busy_cycles", busy_cnt - b0, 16);
        cmp("m3_reads", rd_cnt - r0, 3);
        cmp("m3_last_addr", last_addr, 2);
        cmp("m3_feed_bits", feed_bits - f0, 12);
        cmp("m3_cv_bits", cv_bits - c0, 12);

        // empty tile
        t0 = cyc; b0 = busy_cnt; r0 = rd_cnt; f0 = feed_bits; c0 = cv_bits;
        start = 1; num_vec = 0; tick(); start = 0;
        repeat (10) tick();
        cmp("m0_done_cycle", last_done - t0, 6);
        cmp("m0_busy_cycles", busy_cnt - b0, 5);
        cmp("m0_reads", rd_cnt - r0, 0);
        cmp("m0_feed_cv", (feed_bits - f0) + (cv_bits - c0), 0);

        // oversize tile clamps to MAXM
        t0 = cyc; r0 = rd_cnt;
        start = 1; num_vec = 20; tick(); start = 0;
        repeat (35) tick();
        cmp("clamp_done_cycle", last_done - t0, 3*N + 16 + 2);
        cmp("clamp_reads", rd_cnt - r0, 16);
        cmp("clamp_last_addr", last_addr, 15);

        // abort at relative cycle 9, restart at 11
        t0 = cyc; d0 = done_cnt; f0 = feed_bits; c0 = cv_bits;
        start = 1; num_vec = 3; tick(); start = 0;
        repeat (8) tick();
        abort = 1; tick(); abort = 0;
        tick();
        start = 1; tick(); start = 0;
        repeat (25) tick();
        cmp("abort_done_count", done_cnt - d0, 1);
        cmp("abort_restart_done", last_done - t0, 28);
        cmp("abort_feed_bits", feed_bits - f0, 18);
        cmp("abort_cv_bits", cv_bits - c0, 12);

        // reset mid-stream
        d0 = done_cnt; r0 = rd_cnt;
        start = 1; num_vec = 3; tick(); start = 0;
        repeat (6) tick();
        rst = 1; tick(); rst = 0;
        repeat (5) tick();
        cmp("rst_done_count", done_cnt - d0, 0);
        cmp("rst_reads", rd_cnt - r0, 2);

        // start held high: accepted only in IDLE, back-to-back tiles
        t0 = cyc; d0 = done_cnt;
        start = 1; num_vec = 3;
        repeat (37) tick();
        start = 0;
        repeat (25) tick();
        cmp("hold_done_count", done_cnt - d0, 3);
        cmp("hold_last_done", last_done - t0, 53);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 249) == 0);
            num_vec = NVW'($urandom_range(0, 20));
            tick();
        end
        start = 0; abort = 0; rst = 0;
        repeat (60) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
